// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB bus bundle between requester and apb_slave_mem completer
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer backed by a MEM_DEPTH x DATA_WIDTH register file
// Optional wait states: define APB_SLV_WAIT_EN to insert WAIT_CYCLES extra ACCESS cycles.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_CYCLES = 2
) (
  input logic            pclk,
  input logic            preset,
  apb_slave_mem_if.slave bus
);

  localparam int                LP_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] LP_WAIT      = 4'(WAIT_CYCLES);
  localparam bit         LP_ZERO_WAIT = (WAIT_CYCLES == 0);
`else
  // Without wait states every transfer answers on the SETUP edge; WAIT_CYCLES is legal 0..15.
  localparam bit         LP_ZERO_WAIT = (WAIT_CYCLES >= 0);
`endif

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [LP_IDX_W-1:0]   r_idx;
  logic                  r_in_range;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_pready;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pslverr;
`ifdef APB_SLV_WAIT_EN
  logic [3:0]            r_wait_cnt;
`endif

  logic                  w_setup;
  logic                  w_setup_in_range;
  logic [LP_IDX_W-1:0]   w_setup_idx;

  assign w_setup          = bus.pselx & ~bus.penable;
  assign w_setup_in_range = ({1'b0, bus.paddr} < LP_DEPTH);
  assign w_setup_idx      = bus.paddr[LP_IDX_W-1:0];

  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_in_range <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_pready   <= 1'b0;
      r_prdata   <= '0;
      r_pslverr  <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      r_wait_cnt <= 4'd0;
`endif
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // penable without a preceding SETUP falls through here and is ignored.
          if (w_setup) begin
            r_idx      <= w_setup_idx;
            r_in_range <= w_setup_in_range;
            r_write    <= bus.pwrite;
            r_wdata    <= bus.pwdata;
            r_state    <= S_ACCESS;
`ifdef APB_SLV_WAIT_EN
            r_wait_cnt <= LP_WAIT;
`endif
            if (LP_ZERO_WAIT) begin
              r_pready  <= 1'b1;
              r_pslverr <= ~w_setup_in_range;
              r_prdata  <= (!bus.pwrite && w_setup_in_range) ? r_mem[w_setup_idx] : '0;
            end
          end
        end

        S_ACCESS: begin
          if (!bus.pselx) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_state   <= S_IDLE;
          end else if (r_pready) begin
            if (bus.penable) begin
              if (r_write && r_in_range) r_mem[r_idx] <= r_wdata;
              r_pready  <= 1'b0;
              r_pslverr <= 1'b0;
              r_prdata  <= '0;
              r_state   <= S_IDLE;
            end
          end else begin
`ifdef APB_SLV_WAIT_EN
            if (r_wait_cnt > 4'd1) begin
              r_wait_cnt <= r_wait_cnt - 4'd1;
            end else begin
              r_pready  <= 1'b1;
              r_pslverr <= ~r_in_range;
              r_prdata  <= (!r_write && r_in_range) ? r_mem[r_idx] : '0;
            end
`else
            r_pready  <= 1'b1;
            r_pslverr <= ~r_in_range;
            r_prdata  <= (!r_write && r_in_range) ? r_mem[r_idx] : '0;
`endif
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed vector bench for apb_slave_mem
module tb_apb_slave_mem;

`ifdef APB_SLV_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic pclk;
  logic preset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  apb_slave_mem #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (16),
    .WAIT_CYCLES(2)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          scramble;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transfer; the next call may start SETUP immediately (back-to-back).
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit scr,
                      output logic [31:0] rd, output bit err, output int acc);
    bit done;
    done = 1'b0;
    rd   = '0;
    err  = 1'b0;
    bus.pselx   = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = a;
    bus.pwdata  = d;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    acc = 0;
    while (!done && acc < 20) begin
      acc++;
      if (scr) begin
        bus.pwdata = ~d;
        bus.pwrite = ~wr;
        bus.paddr  = a ^ 8'h01;
      end
      @(negedge pclk);
      if (bus.pready) begin
        rd   = bus.prdata;
        err  = bus.pslverr;
        done = 1'b1;
      end else begin
        chk("wait_prdata", bus.prdata, 32'h0);
        chk("wait_pslverr", {31'h0, bus.pslverr}, 32'h0);
      end
      @(posedge pclk); #1;
    end
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL xfer_timeout: got no pready expected pready within 20 cycles");
    end
  endtask

  vec_t        vecs[$];
  logic [31:0] rd;
  bit          err;
  int          acc;

  initial begin
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    preset      = 1'b1;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("reset_pready", {31'h0, bus.pready}, 32'h0);
    chk("reset_prdata", bus.prdata, 32'h0);
    chk("reset_pslverr", {31'h0, bus.pslverr}, 32'h0);
    @(posedge pclk); #1;

    vecs.push_back('{1'b1, 8'd5,   32'hDEADBEEF, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 8'd5,   32'h0,        1'b0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 8'd16,  32'h00001234, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 8'd16,  32'h0,        1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 8'd15,  32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 8'd0,   32'h11111111, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 8'd15,  32'hFFFFFFFF, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 8'd0,   32'h0,        1'b0, 32'h11111111, 1'b0});
    vecs.push_back('{1'b0, 8'd15,  32'h0,        1'b0, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b1, 8'd255, 32'h00000005, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 8'd255, 32'h0,        1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 8'd7,   32'h00000001, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 8'd7,   32'h0,        1'b0, 32'h00000001, 1'b0});
    vecs.push_back('{1'b0, 8'd6,   32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 8'd5,   32'h0,        1'b0, 32'hDEADBEEF, 1'b0});

    foreach (vecs[i]) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].scramble, rd, err, acc);
      chk($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_pslverr", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_access_cycles", i), 32'(acc), 32'(EXP_WAIT + 1));
    end
    @(negedge pclk);
    chk("idle_after_xfer_pready", {31'h0, bus.pready}, 32'h0);
    @(posedge pclk); #1;

    // Reset held for two clocks in ACCESS of a write: nothing commits, memory cleared.
    xfer(1'b1, 8'd3, 32'h00000077, 1'b0, rd, err, acc);
    bus.pselx   = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 8'd3;
    bus.pwdata  = 32'h00000099;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    preset      = 1'b1;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("midreset_pready", {31'h0, bus.pready}, 32'h0);
    chk("midreset_prdata", bus.prdata, 32'h0);
    @(posedge pclk); #1;
    preset      = 1'b0;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    xfer(1'b0, 8'd3, 32'h0, 1'b0, rd, err, acc);
    chk("after_reset_rd3", rd, 32'h0);
    chk("after_reset_err3", {31'h0, err}, 32'h0);
    xfer(1'b0, 8'd5, 32'h0, 1'b0, rd, err, acc);
    chk("after_reset_rd5", rd, 32'h0);

    // pselx dropped in ACCESS before completion aborts the write.
    xfer(1'b1, 8'd2, 32'h00000055, 1'b0, rd, err, acc);
    bus.pselx   = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 8'd2;
    bus.pwdata  = 32'h000000AA;
    @(posedge pclk); #1;
    bus.pselx   = 1'b0;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("abort_pready", {31'h0, bus.pready}, 32'h0);
    @(posedge pclk); #1;
    xfer(1'b0, 8'd2, 32'h0, 1'b0, rd, err, acc);
    chk("abort_rd2", rd, 32'h00000055);

    // penable with no SETUP is ignored.
    xfer(1'b1, 8'd4, 32'h00000044, 1'b0, rd, err, acc);
    bus.pselx   = 1'b1;
    bus.penable = 1'b1;
    bus.pwrite  = 1'b1;
    bus.paddr   = 8'd4;
    bus.pwdata  = 32'h00000066;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk($sformatf("nosetup_pready_%0d", k), {31'h0, bus.pready}, 32'h0);
    end
    @(posedge pclk); #1;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    @(posedge pclk); #1;
    xfer(1'b0, 8'd4, 32'h0, 1'b0, rd, err, acc);
    chk("nosetup_rd4", rd, 32'h00000044);
    chk("nosetup_cycles", 32'(acc), 32'(EXP_WAIT + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1);
  end

endmodule
